// File: rtl/carry_resolve_nbit_seq.sv
// Sequential carry resolver: takes the raw Sum/Carry vectors from a half-adder array
// and repeatedly half-adds sum and shifted carry until no carry remains, giving a+b.
module carry_resolve_nbit_seq #(
    parameter int N  = 3,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  sum_in,
    input  logic [N-1:0]  carry_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  result,
    output logic          cout,
    output logic [CW-1:0] iter_count,
    output logic [1:0]    state_o
);

    // Handshake: a pair moves on an edge where in_valid && in_ready; a result leaves
    // on an edge where out_valid && out_ready. Data must be stable while valid is high.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [N-1:0]    s_q;
    logic [N-1:0]    c_q;
    logic            cout_q;
    logic [CW-1:0]   iter_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic [N-1:0]    g_d;

    // Generate term of the running half-add; its MSB is a carry out of the word.
    assign g_d = s_q & c_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            s_q         <= '0;
            c_q         <= '0;
            cout_q      <= 1'b0;
            iter_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        s_q        <= sum_in;
                        c_q        <= {carry_in[N-2:0], 1'b0};
                        cout_q     <= carry_in[N-1];
                        iter_q     <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    if (c_q == '0) begin
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        s_q    <= s_q ^ c_q;
                        c_q    <= {g_d[N-2:0], 1'b0};
                        cout_q <= cout_q | g_d[N-1];
                        iter_q <= iter_q + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign result     = s_q;
    assign cout       = cout_q;
    assign iter_count = iter_q;
    assign state_o    = state_q;

endmodule
